// File: rtl/contador_varredura.sv
// Display-scan sequencer: prescaled 2-bit digit index for the 7-segment decoder
// plus active-low one-hot anodes with a blanking window at the start of each slot.
module contador_varredura #(
    parameter int DIV_WIDTH    = 16,
    parameter int DIV_MAX      = 49999,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       congela,
    output logic       saida1Contador,
    output logic       saida2Contador,
    output logic [3:0] anodo,
    output logic       tick
);

    localparam logic [DIV_WIDTH-1:0] DIV_MAX_W = DIV_WIDTH'(DIV_MAX);
    localparam logic [DIV_WIDTH-1:0] BLANK_W   = DIV_WIDTH'(BLANK_CYCLES);

    logic [DIV_WIDTH-1:0] presc_reg, presc_next;
    logic [1:0]           idx_reg, idx_next;
    logic [3:0]           anodo_reg, anodo_next;
    logic                 tick_reg, tick_next;
    logic [3:0]           onehot_n;

    // Active-low decode of the index the display will show after this edge.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            assign onehot_n[gi] = (idx_next != 2'(gi));
        end
    endgenerate

    always_comb begin
        presc_next = presc_reg;
        idx_next   = idx_reg;
        tick_next  = 1'b0;
        if (habilita && !congela) begin
            if (presc_reg == DIV_MAX_W) begin
                presc_next = '0;
                idx_next   = idx_reg + 2'd1;
                tick_next  = 1'b1;
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end
        // Blanking uses the next-state prescaler, so a frozen slot keeps its lit/dark state.
        if (!habilita || (presc_next < BLANK_W)) begin
            anodo_next = 4'b1111;
        end else begin
            anodo_next = onehot_n;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
            idx_reg   <= 2'b00;
            anodo_reg <= 4'b1111;
            tick_reg  <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            idx_reg   <= idx_next;
            anodo_reg <= anodo_next;
            tick_reg  <= tick_next;
        end
    end

    assign saida1Contador = idx_reg[1];
    assign saida2Contador = idx_reg[0];
    assign anodo          = anodo_reg;
    assign tick           = tick_reg;

endmodule

// File: tb/tb_contador_varredura.sv
// Directed bench for contador_varredura with DIV_MAX=7, BLANK_CYCLES=2.
module tb_contador_varredura;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       habilita = 1'b1;
    logic       congela = 1'b0;
    logic       saida1Contador, saida2Contador;
    logic [3:0] anodo;
    logic       tick;

    int checks = 0;
    int errors = 0;

    contador_varredura #(
        .DIV_WIDTH(16), .DIV_MAX(7), .BLANK_CYCLES(2)
    ) dut (
        .clock(clock), .reset(reset), .habilita(habilita), .congela(congela),
        .saida1Contador(saida1Contador), .saida2Contador(saida2Contador),
        .anodo(anodo), .tick(tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       hab;
        logic       cong;
        logic [1:0] idx;
        logic [3:0] an;
        logic       tk;
    } vec_t;

    vec_t tbl[32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [1:0] ei, input logic [3:0] ea, input logic et);
        chk({nm, ".idx"}, {30'd0, saida1Contador, saida2Contador}, {30'd0, ei});
        chk({nm, ".anodo"}, {28'd0, anodo}, {28'd0, ea});
        chk({nm, ".tick"}, {31'd0, tick}, {31'd0, et});
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later, check anode exclusivity.
    task automatic step(input logic h, input logic c);
        habilita = h;
        congela  = c;
        @(posedge clock);
        #1;
        chk("one_anode", {31'd0, ($countones(~anodo) <= 1)}, 32'd1);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 32; i++) begin
            step(tbl[i].hab, tbl[i].cong);
            chk_out($sformatf("%s_e%0d", tag, i + 1), tbl[i].idx, tbl[i].an, tbl[i].tk);
            $display("%s edge %0d idx=%b%b anodo=%b tick=%b", tag, i + 1,
                     saida1Contador, saida2Contador, anodo, tick);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Edge e after reset: presc = e mod 8, idx = (e/8) mod 4; dark while presc < 2.
        for (int e = 1; e <= 32; e++) begin
            int p, s;
            p = e % 8;
            s = (e / 8) % 4;
            tbl[e-1].hab  = 1'b1;
            tbl[e-1].cong = 1'b0;
            tbl[e-1].idx  = 2'(s);
            tbl[e-1].an   = (p < 2) ? 4'b1111 : ~(4'b0001 << s);
            tbl[e-1].tk   = (p == 0);
        end

        // Reset state while habilita=1
        repeat (2) @(posedge clock);
        #1;
        chk_out("reset", 2'b00, 4'b1111, 1'b0);
        $display("reset idx=%b%b anodo=%b tick=%b", saida1Contador, saida2Contador, anodo, tick);
        @(negedge clock);
        reset = 1'b0;

        // Full rotation, blanking and wrap; ends at presc=0 idx=00
        run_table("rot");

        // Advance to presc=5 idx=10, then freeze for 20 clocks
        repeat (21) step(1'b1, 1'b0);
        chk_out("pre_freeze", 2'b10, 4'b1011, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            chk_out($sformatf("freeze_%0d", i), 2'b10, 4'b1011, 1'b0);
        end
        $display("freeze held idx=%b%b anodo=%b", saida1Contador, saida2Contador, anodo);
        step(1'b1, 1'b0);
        chk_out("unfreeze_1", 2'b10, 4'b1011, 1'b0);
        step(1'b1, 1'b0);
        chk_out("unfreeze_2", 2'b10, 4'b1011, 1'b0);
        step(1'b1, 1'b0);
        chk_out("unfreeze_3", 2'b11, 4'b1111, 1'b1);
        $display("unfreeze advance idx=%b%b tick=%b", saida1Contador, saida2Contador, tick);

        // From presc=0 idx=11 to presc=3 idx=01, then disable for 5 clocks
        repeat (19) step(1'b1, 1'b0);
        chk_out("pre_disable", 2'b01, 4'b1101, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            chk_out($sformatf("disable_%0d", i), 2'b01, 4'b1111, 1'b0);
        end
        $display("disabled idx=%b%b anodo=%b", saida1Contador, saida2Contador, anodo);
        step(1'b1, 1'b0);
        chk_out("enable_1", 2'b01, 4'b1101, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            step(1'b1, 1'b0);
            chk_out($sformatf("enable_%0d", i), 2'b01, 4'b1101, 1'b0);
        end
        step(1'b1, 1'b0);
        chk_out("enable_5", 2'b10, 4'b1111, 1'b1);
        $display("enable advance idx=%b%b tick=%b", saida1Contador, saida2Contador, tick);

        // From presc=0 idx=10 to presc=6 idx=11, then reset between edges
        repeat (14) step(1'b1, 1'b0);
        chk_out("pre_reset", 2'b11, 4'b0111, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_reset", 2'b00, 4'b1111, 1'b0);
        $display("async reset idx=%b%b anodo=%b tick=%b", saida1Contador, saida2Contador, anodo, tick);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_table("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_varredura.md
Name: contador_varredura

Overview:
- Display-scan sequencer directly upstream of the 7-segment letter decoder of the coffee-machine panel.
- Generates the 2-bit digit index consumed by the decoder as saida1Contador (MSB) and saida2Contador (LSB).
- Also drives the active-low one-hot digit anodes, so a four-digit multiplexed display shows one character per slot.
- A prescaler sets the slot length; a short blanking window at each slot start suppresses ghosting while the decoder settles.

Parameters:
DIV_WIDTH, 16, prescaler register width.
DIV_MAX, 49999, clocks per digit slot minus 1; must fit in DIV_WIDTH bits.
BLANK_CYCLES, 4, clocks at the start of each slot with all anodes off; must satisfy 0 < BLANK_CYCLES <= DIV_MAX.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
habilita  input  1  scan enable; 0 = display dark, state held.
congela  input  1  freeze on the current digit (test/diagnostic hold).
saida1Contador  output  1  digit index MSB, to the decoder.
saida2Contador  output  1  digit index LSB, to the decoder.
anodo  output  4  digit enables, active-low one-hot; anodo[i]=0 lights digit i.
tick  output  1  one-clock pulse on each index advance.

Behaviour:
- Registers:
  - presc, DIV_WIDTH bits.
  - idx, 2 bits; saida1Contador=idx[1], saida2Contador=idx[0].
  - anodo, 4 bits, registered.
  - tick, registered.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset (asynchronous, takes effect without a clock edge): presc=0, idx=00, anodo=1111, tick=0.
- Per-edge priority: reset > habilita=0 > congela=1 > normal count.
- habilita=0:
  - presc and idx hold.
  - anodo=1111 from the next edge.
  - tick=0.
- congela=1 with habilita=1:
  - presc and idx hold.
  - tick=0.
  - anodo = one-hot of idx if the held presc >= BLANK_CYCLES, else 1111.
- Normal count (habilita=1, congela=0):
  - presc<DIV_MAX: presc+1, idx unchanged, tick=0.
  - presc==DIV_MAX: presc=0, idx=idx+1 mod 4 (11 wraps to 00), tick=1 for exactly that cycle.
- anodo rule: anodo is updated from the next-state values of presc, idx and habilita.
  - anodo = 1111 when next presc < BLANK_CYCLES or habilita=0.
  - Otherwise anodo = ~(0001 << next idx).
- Slot timing:
  - Slot length is DIV_MAX+1 clocks.
  - Anodes are lit for DIV_MAX+1-BLANK_CYCLES of those clocks.
  - idx changes on the same edge that blanks the anodes, so the decoder has BLANK_CYCLES clocks to settle.
- Resume after habilita or congela is released: counting continues from the held presc/idx with no skipped or repeated slot, and presc is not restarted.
- Never more than one anode low at any time.
- The first slot after reset also starts with the blanking window.

Test Plan:
All scenarios use DIV_MAX=7, BLANK_CYCLES=2.
1. Reset behaviour: assert reset with habilita=1 -> idx=00, anodo=1111, tick=0. Release reset -> anodo=1111 for edges 1, then anodo=1110 from edge 2 through edge 7.
2. Full rotation: habilita=1 for 32 clocks -> idx goes 00,01,10,11,00 at edges 8,16,24,32; tick=1 only on those cycles; anodo shows 1110, 1101, 1011, 0111 in turn.
3. Blanking window: at the edge where idx becomes 01 -> anodo=1111 for 2 clocks, then 1101 for 6 clocks. Check that no cycle ever has two anodes low.
4. Freeze: assert congela at presc=5 with idx=10 for 20 clocks -> idx stays 10, anodo=1011, tick=0. Release congela -> advance to 11 occurs 3 clocks later.
5. Disable: drop habilita at presc=3 with idx=01 -> anodo=1111 from the next edge, presc and idx hold. Re-raise habilita -> anodo=1101 on the next edge, advance to 10 occurs 5 clocks later.
6. Mid-slot reset: pulse reset asynchronously between edges at presc=6 with idx=11 -> outputs are 00/1111/0 immediately, before any clock edge. Normal sequence restarts as in scenario 1.
